uart_tx: RTL and testbench

Serial transmitter that drains bytes from the UART transmit FIFO and shifts them out as asynchronous 8N1/8N2 frames on the `tx` line. Sits directly downstream of the transmit FIFO, talking to its read side through the single-cycle `readReq`/`readAck` handshake. Its output pin goes to the board-level TXD.

---
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Control, FIFO read handshake and serial line of the UART
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  txEnable;
    logic                  fifoEmpty;
    logic                  fifoReadReq;
    logic                  fifoReadAck;
    logic [DATA_WIDTH-1:0] fifoData;
    logic                  tx;
    logic                  busy;

    // master: the transmitter; slave: FIFO read side plus control/line owner
    modport master (
        input  txEnable, fifoEmpty, fifoReadAck, fifoData,
        output fifoReadReq, tx, busy
    );

    modport slave (
        output txEnable, fifoEmpty, fifoReadAck, fifoData,
        input  fifoReadReq, tx, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Drains bytes from the transmit FIFO and shifts them out as
//               8N1/8N2 asynchronous frames, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input wire        clk,
    input wire        rst,
    uart_tx_if.master bus
);

    localparam int c_cntW = $clog2(CLKS_PER_BIT);
    localparam int c_bitW = $clog2(DATA_WIDTH + 1);

    localparam logic [c_cntW-1:0] c_baudLast = c_cntW'(CLKS_PER_BIT - 1);
    localparam logic [c_bitW-1:0] c_lastBit  = c_bitW'(DATA_WIDTH - 1);
    localparam logic [c_bitW-1:0] c_lastStop = c_bitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    state_t                r_state,   w_state;
    logic                  r_tx,      w_tx;
    logic                  r_readReq, w_readReq;
    logic                  r_busy,    w_busy;
    logic [c_cntW-1:0]     r_baud,    w_baud;
    logic [c_bitW-1:0]     r_bitCnt,  w_bitCnt;
    logic [DATA_WIDTH-1:0] r_shift,   w_shift;
    logic                  w_baudEnd;

    assign w_baudEnd = (r_baud == c_baudLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_readReq <= 1'b0;
            r_busy    <= 1'b0;
            r_baud    <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state;
            r_tx      <= w_tx;
            r_readReq <= w_readReq;
            r_busy    <= w_busy;
            r_baud    <= w_baud;
            r_bitCnt  <= w_bitCnt;
            r_shift   <= w_shift;
        end
    end

    // Registered outputs are computed one state ahead so they line up with r_state.
    always_comb begin
        w_state   = r_state;
        w_tx      = r_tx;
        w_readReq = 1'b0;
        w_baud    = r_baud;
        w_bitCnt  = r_bitCnt;
        w_shift   = r_shift;

        case (r_state)
            ST_IDLE: begin
                w_tx = 1'b1;
                if (bus.txEnable && !bus.fifoEmpty) begin
                    w_state   = ST_REQ;
                    w_readReq = 1'b1;
                end
            end
            ST_REQ: begin
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.fifoReadAck) begin
                    w_shift  = bus.fifoData;
                    w_tx     = 1'b0;
                    w_baud   = '0;
                    w_bitCnt = '0;
                    w_state  = ST_START;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_baudEnd) begin
                    w_baud  = '0;
                    w_tx    = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_state = ST_DATA;
                end else begin
                    w_baud = r_baud + c_cntW'(1);
                end
            end
            ST_DATA: begin
                if (w_baudEnd) begin
                    w_baud = '0;
                    if (r_bitCnt == c_lastBit) begin
                        w_tx     = 1'b1;
                        w_bitCnt = '0;
                        w_state  = ST_STOP;
                    end else begin
                        w_tx     = r_shift[0];
                        w_shift  = r_shift >> 1;
                        w_bitCnt = r_bitCnt + c_bitW'(1);
                    end
                end else begin
                    w_baud = r_baud + c_cntW'(1);
                end
            end
            ST_STOP: begin
                // The bit counter is reused to count stop-bit periods.
                if (w_baudEnd) begin
                    w_baud = '0;
                    if (r_bitCnt == c_lastStop) begin
                        w_bitCnt = '0;
                        w_state  = ST_IDLE;
                    end else begin
                        w_bitCnt = r_bitCnt + c_bitW'(1);
                    end
                end else begin
                    w_baud = r_baud + c_cntW'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_tx    = 1'b1;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign bus.tx          = r_tx;
    assign bus.fifoReadReq = r_readReq;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx; per-cycle line/busy/request
//               traces are compared with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8)) busA ();
    uart_tx_if #(.DATA_WIDTH(8)) busB ();

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] qA[$];
    logic [7:0] qB[$];
    logic [7:0] modelBytes[$];
    logic [2:0] aTr[$];
    logic [2:0] bTr[$];
    logic [2:0] expV[$];
    bit         recA = 1'b0;
    bit         recB = 1'b0;
    bit         suppressA = 1'b0;
    logic       prevReqA = 1'b0;
    logic       prevReqB = 1'b0;

    // FIFO read side: acknowledge one cycle after a request; record {tx,busy,req}.
    always @(negedge clk) begin
        if (recA) aTr.push_back({busA.tx, busA.busy, busA.fifoReadReq});
        if (prevReqA && !suppressA && qA.size() > 0) begin
            busA.fifoReadAck = 1'b1;
            busA.fifoData    = qA.pop_front();
        end else begin
            busA.fifoReadAck = 1'b0;
        end
        prevReqA       = busA.fifoReadReq;
        busA.fifoEmpty = (qA.size() == 0);
    end

    always @(negedge clk) begin
        if (recB) bTr.push_back({busB.tx, busB.busy, busB.fifoReadReq});
        if (prevReqB && qB.size() > 0) begin
            busB.fifoReadAck = 1'b1;
            busB.fifoData    = qB.pop_front();
        end else begin
            busB.fifoReadAck = 1'b0;
        end
        prevReqB       = busB.fifoReadReq;
        busB.fifoEmpty = (qB.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            testsFailed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each byte: IDLE, REQ, WAIT samples, then start/data/stop bits of CPB cycles each.
    task automatic buildModel(input int stopBits, input int len);
        logic b;
        expV.delete();
        foreach (modelBytes[k]) begin
            expV.push_back(3'b100);
            expV.push_back(3'b111);
            expV.push_back(3'b110);
            for (int p = 0; p < 9 + stopBits; p++) begin
                if (p == 0)      b = 1'b0;
                else if (p <= 8) b = modelBytes[k][p-1];
                else             b = 1'b1;
                repeat (CPB) expV.push_back({b, 2'b10});
            end
        end
        while (expV.size() < len) expV.push_back(3'b100);
    endtask

    task automatic checkTrace(input string tag, input bit useB, input int len);
        logic [2:0] got;
        int         n;
        int         bad;
        logic       g;
        logic       e;
        string      sig;
        n = useB ? bTr.size() : aTr.size();
        chk({tag, "_len"}, 32'(n >= len), 32'd1);
        for (int s = 0; s < 3; s++) begin
            bad = -1;
            g   = 1'b0;
            e   = 1'b0;
            for (int i = 0; i < len && i < n; i++) begin
                got = useB ? bTr[i] : aTr[i];
                if (bad < 0 && got[s] !== expV[i][s]) begin
                    bad = i;
                    g   = got[s];
                    e   = expV[i][s];
                end
            end
            sig = (s == 0) ? "req" : (s == 1) ? "busy" : "tx";
            testsRun++;
            assert (bad < 0) else begin
                testsFailed++;
                $error("FAIL %s_%s at sample %0d: got %b expected %b", tag, sig, bad, g, e);
            end
        end
    endtask

    function automatic int countReqA(input int len);
        int c = 0;
        for (int i = 0; i < len && i < aTr.size(); i++) c += int'(aTr[i][0]);
        return c;
    endfunction

    task automatic recordA(input int len);
        aTr.delete();
        recA = 1'b1;
        repeat (len) @(posedge clk);
        #1 recA = 1'b0;
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] y;
        int         len;
        int         idx;
        int         run0;
        int         run1;

        rst           = 1'b0;
        busA.txEnable = 1'b0;
        busB.txEnable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_A",   32'(busA.tx),          32'd1);
        chk("reset_busy_A", 32'(busA.busy),        32'd0);
        chk("reset_req_A",  32'(busA.fifoReadReq), 32'd0);
        chk("reset_tx_B",   32'(busB.tx),          32'd1);
        chk("reset_busy_B", 32'(busB.busy),        32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        busA.txEnable = 1'b1;
        busB.txEnable = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single byte 0x55
        qA.push_back(8'h55);
        modelBytes.delete(); modelBytes.push_back(8'h55);
        buildModel(1, 48);
        recordA(48);
        checkTrace("single", 1'b0, 48);
        chk("single_req_pulses", 32'(countReqA(48)), 32'd1);

        // Back-to-back 0xA5, 0x3C
        qA.push_back(8'hA5); qA.push_back(8'h3C);
        modelBytes.delete(); modelBytes.push_back(8'hA5); modelBytes.push_back(8'h3C);
        buildModel(1, 91);
        recordA(91);
        checkTrace("b2b", 1'b0, 91);
        chk("b2b_req_pulses", 32'(countReqA(91)), 32'd2);

        // Random back-to-back bytes
        modelBytes.delete();
        for (int i = 0; i < 4; i++) begin
            x = 8'($urandom);
            qA.push_back(x);
            modelBytes.push_back(x);
        end
        len = 4 * 43 + 5;
        buildModel(1, len);
        recordA(len);
        checkTrace("random", 1'b0, len);

        // Enable dropped mid-frame: frame completes, second byte stays queued
        x = 8'($urandom);
        y = 8'($urandom);
        qA.push_back(x); qA.push_back(y);
        modelBytes.delete(); modelBytes.push_back(x);
        buildModel(1, 63);
        aTr.delete();
        recA = 1'b1;
        repeat (20) @(posedge clk);
        #1 busA.txEnable = 1'b0;
        repeat (43) @(posedge clk);
        #1 recA = 1'b0;
        checkTrace("gated", 1'b0, 63);
        chk("gated_req_pulses", 32'(countReqA(63)), 32'd1);
        busA.txEnable = 1'b1;
        modelBytes.delete(); modelBytes.push_back(y);
        buildModel(1, 48);
        recordA(48);
        checkTrace("reenable", 1'b0, 48);

        // Missing ack: WAIT aborts to IDLE, retries every 3 cycles
        suppressA = 1'b1;
        x = 8'($urandom);
        qA.push_back(x);
        modelBytes.delete(); modelBytes.push_back(x);
        buildModel(1, 48);
        for (int i = 11; i >= 0; i--)
            expV.push_front((i % 3 == 0) ? 3'b100 : (i % 3 == 1) ? 3'b111 : 3'b110);
        aTr.delete();
        recA = 1'b1;
        repeat (12) @(posedge clk);
        #1 suppressA = 1'b0;
        repeat (48) @(posedge clk);
        #1 recA = 1'b0;
        checkTrace("noack", 1'b0, 60);

        // Reset during DATA bit 3 of 0x00
        y = 8'($urandom);
        qA.push_back(8'h00); qA.push_back(y);
        aTr.delete();
        recA = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("midframe_tx_bit3",  32'(busA.tx),   32'd0);
        chk("midframe_busy",     32'(busA.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_tx",   32'(busA.tx),          32'd1);
        chk("rst_async_busy", 32'(busA.busy),        32'd0);
        chk("rst_async_req",  32'(busA.fifoReadReq), 32'd0);
        recA = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        modelBytes.delete(); modelBytes.push_back(y);
        buildModel(1, 48);
        recordA(48);
        checkTrace("after_rst", 1'b0, 48);

        // Two stop bits: 0xFF, 0xFF, random
        x = 8'($urandom);
        qB.push_back(8'hFF); qB.push_back(8'hFF); qB.push_back(x);
        modelBytes.delete();
        modelBytes.push_back(8'hFF); modelBytes.push_back(8'hFF); modelBytes.push_back(x);
        len = 3 * 47 + 5;
        buildModel(2, len);
        bTr.delete();
        recB = 1'b1;
        repeat (len) @(posedge clk);
        #1 recB = 1'b0;
        checkTrace("stop2", 1'b1, len);
        idx = 0;
        while (idx < bTr.size() && bTr[idx][2]) idx++;
        run0 = 0;
        while (idx < bTr.size() && !bTr[idx][2]) begin run0++; idx++; end
        run1 = 0;
        while (idx < bTr.size() && bTr[idx][2]) begin run1++; idx++; end
        chk("stop2_low_run",  32'(run0), 32'd4);
        chk("stop2_high_run", 32'(run1), 32'(32 + 8 + 3));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
`default_nettype wire
